uart_rx_byte: RTL and testbench

Asynchronous serial receiver: recovers 8N1 frames from the `Uart_rx` line and presents each received byte with a one-cycle done strobe. It is the receive-side counterpart of the byte transmitter, sharing the same 50 MHz system clock (20 ns) and the same `Baud_sel` encoding. It uses 16x oversampling with 3-sample majority voting, and flags framing errors (and optionally parity errors).

---
 rtl/uart_pkg.sv | 58 +++++
 rtl/uart_rx_baud_tick.sv | 37 +++
 rtl/uart_rx_byte.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisors, full-bit counts, receiver FSM encoding and small helpers.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned TICK_CNT_W = $clog2(OVERSAMPLE);

  // Majority window sits on the slots either side of the bit centre
  localparam logic [TICK_CNT_W-1:0] SLOT_EARLY = TICK_CNT_W'(SAMPLE_MID - 1);
  localparam logic [TICK_CNT_W-1:0] SLOT_MID   = TICK_CNT_W'(SAMPLE_MID);
  localparam logic [TICK_CNT_W-1:0] SLOT_LATE  = TICK_CNT_W'(SAMPLE_MID + 1);

  localparam logic [8:0] BAUD_DIV_9600   = 9'd324;
  localparam logic [8:0] BAUD_DIV_19200  = 9'd162;
  localparam logic [8:0] BAUD_DIV_38400  = 9'd80;
  localparam logic [8:0] BAUD_DIV_57600  = 9'd53;
  localparam logic [8:0] BAUD_DIV_115200 = 9'd26;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic [8:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd0:    baud_div = BAUD_DIV_9600;
      3'd1:    baud_div = BAUD_DIV_19200;
      3'd2:    baud_div = BAUD_DIV_38400;
      3'd3:    baud_div = BAUD_DIV_57600;
      3'd4:    baud_div = BAUD_DIV_115200;
      default: baud_div = BAUD_DIV_9600;
    endcase
  endfunction

  // Full-bit clock counts used by the transmitter side
  function automatic logic [12:0] baud_bit_cycles(input logic [2:0] sel);
    case (sel)
      3'd0:    baud_bit_cycles = 13'd5208;
      3'd1:    baud_bit_cycles = 13'd2604;
      3'd2:    baud_bit_cycles = 13'd1302;
      3'd3:    baud_bit_cycles = 13'd868;
      3'd4:    baud_bit_cycles = 13'd434;
      default: baud_bit_cycles = 13'd5208;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// 16x oversampling tick: one-cycle pulse every div_i+1 clocks while enabled; clr_i realigns phase.
module uart_rx_baud_tick (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [8:0] div_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o
);

  logic [8:0] cnt_q;
  logic       tick_q;

  // Divider counter with registered tick
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= 9'd0;
      tick_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= 9'd0;
      tick_q <= 1'b0;
    end else if (en_i) begin
      if (cnt_q == div_i) begin
        cnt_q  <= 9'd0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 9'd1;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Define UART_RX_PARITY_EN for 8E1 frames with a live Parity_err strobe.
module uart_rx_byte
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] Baud_sel,
  input  logic       Uart_rx,
  output logic [7:0] Data_byte,
  output logic       Rx_done,
  output logic       Frame_err,
  output logic       Parity_err,
  output logic       Uart_state
);

  logic                  rx_s1_q, rx_s2_q, rx_s3_q;
  logic                  start_edge_s, run_s, tick_s;
  rx_state_e             state_q;
  logic [8:0]            div_q;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]            samp_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q, data_q;
  logic                  rx_done_q, frame_err_q, uart_state_q;
  logic                  sample_s, decide_s, bit_end_s, maj_s;
`ifdef UART_RX_PARITY_EN
  logic                  par_pend_q, parity_err_q;
`endif

  // Two-flop synchronizer plus edge-detect stage, idle-high reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= Uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign start_edge_s = (state_q == ST_IDLE) && rx_s3_q && !rx_s2_q;
  assign run_s        = (state_q != ST_IDLE);

  uart_rx_baud_tick u_tick (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .div_i  (div_q),
    .en_i   (run_s),
    .clr_i  (start_edge_s),
    .tick_o (tick_s)
  );

  // Slot decode: the counter value after this tick selects sample, decision and bit end
  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    sample_s   = tick_s && ((tick_cnt_d == SLOT_EARLY) || (tick_cnt_d == SLOT_MID));
    decide_s   = tick_s && (tick_cnt_d == SLOT_LATE);
    bit_end_s  = tick_s && (tick_cnt_d == '0);
    maj_s      = maj3(samp_q[1], samp_q[0], rx_s2_q);
  end

  // Receive FSM with shift register and registered status strobes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      div_q        <= BAUD_DIV_9600;
      tick_cnt_q   <= '0;
      samp_q       <= 2'b00;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      uart_state_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (sample_s) begin
        samp_q <= {samp_q[0], rx_s2_q};
      end
      if (run_s && tick_s) begin
        tick_cnt_q <= tick_cnt_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_q      <= ST_START;
            uart_state_q <= 1'b1;
            div_q        <= baud_div(Baud_sel);
            tick_cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (decide_s && maj_s) begin
            state_q      <= ST_IDLE;
            uart_state_q <= 1'b0;
          end else if (bit_end_s) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        ST_DATA: begin
          if (decide_s) begin
            shift_q <= {maj_s, shift_q[7:1]};
          end
          if (bit_end_s) begin
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (decide_s) begin
            par_pend_q <= (maj_s != even_parity(shift_q));
          end
          if (bit_end_s) begin
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leave at the decision point so a back-to-back start edge is not missed
          if (decide_s) begin
            state_q      <= ST_IDLE;
            uart_state_q <= 1'b0;
            if (maj_s) begin
              data_q    <= shift_q;
              rx_done_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_pend_q;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_pend_q <= 1'b0;
`endif
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          uart_state_q <= 1'b0;
        end
      endcase
    end
  end

  assign Data_byte  = data_q;
  assign Rx_done    = rx_done_q;
  assign Frame_err  = frame_err_q;
  assign Uart_state = uart_state_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_err = parity_err_q;
`else
  assign Parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: directed frames push expectations, a monitor checks each strobe.
module tb_uart_rx_byte;
  import uart_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] Baud_sel = 3'd4;
  logic       Uart_rx = 1'b1;
  logic [7:0] Data_byte;
  logic       Rx_done, Frame_err, Parity_err, Uart_state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #10 Clk = ~Clk;

  uart_rx_byte dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Baud_sel   (Baud_sel),
    .Uart_rx    (Uart_rx),
    .Data_byte  (Data_byte),
    .Rx_done    (Rx_done),
    .Frame_err  (Frame_err),
    .Parity_err (Parity_err),
    .Uart_state (Uart_state)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int cycles);
    Uart_rx = lvl;
    repeat (cycles) @(posedge Clk);
    #1;
  endtask

  // Pushes the expected outcome, then drives start, data (LSB first), optional parity and stop
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                            input logic chk_lat);
    int n;
    exp_t e;
    n = int'(baud_bit_cycles(Baud_sel));
    e.fe = ~stop;
    e.pe = bad_par & stop;
    e.data = d;
    exp_q.push_back(e);
    if (chk_lat) begin
      Uart_rx = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      chk("state_lat_2clk", Uart_state, 8'd0);
      @(posedge Clk); #1;
      chk("state_lat_3clk", Uart_state, 8'd1);
      drive(1'b0, n - 3);
    end else begin
      drive(1'b0, n);
    end
    for (int i = 0; i < 8; i++) drive(d[i], n);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ bad_par, n);
`endif
    drive(stop, n);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge Clk) begin
    if (Rst_n && (Rx_done || Frame_err || Parity_err)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: done=%0b ferr=%0b perr=%0b, expected none",
                 Rx_done, Frame_err, Parity_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_rx_done", {7'd0, Rx_done}, {7'd0, ~mon_e.fe});
        chk("mon_frame_err", {7'd0, Frame_err}, {7'd0, mon_e.fe});
        chk("mon_parity_err", {7'd0, Parity_err}, {7'd0, mon_e.pe});
        if (!mon_e.fe) chk("mon_data", Data_byte, mon_e.data);
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (5) @(posedge Clk);
    #1;
    chk("rst_data", Data_byte, 8'h00);
    chk("rst_done", {7'd0, Rx_done}, 8'd0);
    chk("rst_ferr", {7'd0, Frame_err}, 8'd0);
    chk("rst_perr", {7'd0, Parity_err}, 8'd0);
    chk("rst_state", {7'd0, Uart_state}, 8'd0);
    Rst_n = 1'b1;
    drive(1'b1, 20);

    // 0x55 at 115200
    Baud_sel = 3'd4;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 100);
    chk("t1_state_idle", {7'd0, Uart_state}, 8'd0);
    chk("t1_pending", 8'(exp_q.size()), 8'd0);
    chk("t1_data", Data_byte, 8'h55);

    // 50-cycle glitch at 9600: false start, no strobes
    Baud_sel = 3'd0;
    drive(1'b0, 50);
    Uart_rx = 1'b1;
    chk("glitch_state_busy", {7'd0, Uart_state}, 8'd1);
    drive(1'b1, 5208 - 50);
    chk("glitch_state_idle", {7'd0, Uart_state}, 8'd0);
    chk("glitch_data_hold", Data_byte, 8'h55);

    // 0xA3 with low stop bit at 38400
    Baud_sel = 3'd2;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2 * 1302);
    chk("ferr_data_hold", Data_byte, 8'h55);
    chk("ferr_pending", 8'(exp_q.size()), 8'd0);
    chk("ferr_state_idle", {7'd0, Uart_state}, 8'd0);

    // Back-to-back 0x00, 0xFF at 9600
    Baud_sel = 3'd0;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 200);
    chk("b2b_pending", 8'(exp_q.size()), 8'd0);
    chk("b2b_data", Data_byte, 8'hFF);

    // Reset in the middle of data bit 4 at 57600, then 0x3C
    Baud_sel = 3'd3;
    n = 868;
    drive(1'b0, n);
    for (int i = 0; i < 4; i++) drive(n_bit(8'h3C, i), n);
    drive(n_bit(8'h3C, 4), n / 2);
    chk("pre_rst_state", {7'd0, Uart_state}, 8'd1);
    Rst_n = 1'b0;
    Uart_rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("mid_rst_data", Data_byte, 8'h00);
    chk("mid_rst_done", {7'd0, Rx_done}, 8'd0);
    chk("mid_rst_ferr", {7'd0, Frame_err}, 8'd0);
    chk("mid_rst_perr", {7'd0, Parity_err}, 8'd0);
    chk("mid_rst_state", {7'd0, Uart_state}, 8'd0);
    Rst_n = 1'b1;
    drive(1'b1, 50);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 200);
    chk("post_rst_data", Data_byte, 8'h3C);
    chk("post_rst_pending", 8'(exp_q.size()), 8'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with wrong (zero) parity at 115200
    Baud_sel = 3'd4;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 100);
    chk("par_data", Data_byte, 8'h07);
    chk("par_pending", 8'(exp_q.size()), 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic n_bit(input logic [7:0] d, input int i);
    n_bit = d[i];
  endfunction

endmodule
